// File: rtl/cache_axi_arbiter.sv
// Shares one cache-line burst engine between I-cache refills and D-cache refills/write-backs.
// Latches a single client request, holds the engine request stable and routes the completion back.
module cache_axi_arbiter #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       i_rd_req,
    input  logic [31:0]                i_addr,
    output logic                       i_gnt,
    output logic [32*LINE_WORDS-1:0]   i_rd_line,
    input  logic                       d_rd_req,
    input  logic                       d_wr_req,
    input  logic [31:0]                d_addr,
    input  logic [32*LINE_WORDS-1:0]   d_wr_line,
    output logic                       d_gnt,
    output logic [32*LINE_WORDS-1:0]   d_rd_line,
    output logic                       m_rd_req,
    output logic                       m_wr_req,
    output logic [31:0]                m_addr,
    output logic [32*LINE_WORDS-1:0]   m_wr_line,
    input  logic                       m_gnt,
    input  logic [32*LINE_WORDS-1:0]   m_rd_line,
    output logic                       busy
);
    localparam int unsigned LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;          // 1: D-cache owns the engine
    logic                last_owner_q, last_owner_d;
    logic                m_rd_req_q, m_rd_req_d;
    logic                m_wr_req_q, m_wr_req_d;
    logic [31:0]         m_addr_q, m_addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                busy_q, busy_d;

    logic                i_pend, d_pend, req_any, pick_d, pick_wr;

    // Fair choice: a lone requester wins, a tie goes to whoever was not served last.
    assign i_pend  = i_rd_req;
    assign d_pend  = d_rd_req | d_wr_req;
    assign req_any = i_pend | d_pend;
    assign pick_d  = d_pend & (~i_pend | ~last_owner_q);
    assign pick_wr = pick_d & d_wr_req;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            m_rd_req_q   <= 1'b0;
            m_wr_req_q   <= 1'b0;
            m_addr_q     <= 32'd0;
            line_q       <= LINE_W'(0);
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            m_rd_req_q   <= m_rd_req_d;
            m_wr_req_q   <= m_wr_req_d;
            m_addr_q     <= m_addr_d;
            line_q       <= line_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = BUSY;
            BUSY:    if (m_gnt) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Engine-side registers only load from client inputs at acceptance in IDLE.
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        m_rd_req_d   = m_rd_req_q;
        m_wr_req_d   = m_wr_req_q;
        m_addr_d     = m_addr_q;
        line_d       = line_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d    = pick_d;
                    m_rd_req_d = ~pick_wr;
                    m_wr_req_d = pick_wr;
                    m_addr_d   = pick_d ? d_addr : i_addr;
                    busy_d     = 1'b1;
                    if (pick_wr) begin
                        line_d = d_wr_line;
                    end
                end
            end
            BUSY: begin
                if (m_gnt) begin
                    m_rd_req_d   = 1'b0;
                    m_wr_req_d   = 1'b0;
                    last_owner_d = owner_q;
                end
            end
            DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                m_rd_req_d = 1'b0;
                m_wr_req_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Completion is forwarded only while a transfer is owned and not under reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (aresetn && (state_q == BUSY) && m_gnt) begin
            i_gnt = ~owner_q;
            d_gnt = owner_q;
        end
    end

    assign i_rd_line = m_rd_line;
    assign d_rd_line = m_rd_line;
    assign m_rd_req  = m_rd_req_q;
    assign m_wr_req  = m_wr_req_q;
    assign m_addr    = m_addr_q;
    assign m_wr_line = line_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Self-checking bench for cache_axi_arbiter: directed scenarios then random traffic,
// checked against a transaction-level arbitration model.
module tb_cache_axi_arbiter;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LW = 32 * LINE_WORDS;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          i_rd_req;
    logic [31:0]   i_addr;
    logic          i_gnt;
    logic [LW-1:0] i_rd_line;
    logic          d_rd_req;
    logic          d_wr_req;
    logic [31:0]   d_addr;
    logic [LW-1:0] d_wr_line;
    logic          d_gnt;
    logic [LW-1:0] d_rd_line;
    logic          m_rd_req;
    logic          m_wr_req;
    logic [31:0]   m_addr;
    logic [LW-1:0] m_wr_line;
    logic          m_gnt;
    logic [LW-1:0] m_rd_line;
    logic          busy;

    int            n_chk  = 0;
    int            n_fail = 0;
    bit            mdl_last_d;      // model: D-cache was the last served client
    logic [LW-1:0] last_got;
    logic [LW-1:0] last_wr;

    cache_axi_arbiter #(.LINE_WORDS(LINE_WORDS)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_rd_req  (i_rd_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rd_line (i_rd_line),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wr_line (d_wr_line),
        .d_gnt     (d_gnt),
        .d_rd_line (d_rd_line),
        .m_rd_req  (m_rd_req),
        .m_wr_req  (m_wr_req),
        .m_addr    (m_addr),
        .m_wr_line (m_wr_line),
        .m_gnt     (m_gnt),
        .m_rd_line (m_rd_line),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        l = '0;
        for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [LW-1:0] seq_line(input logic [31:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = base + 32'(w);
        return l;
    endfunction

    // Who should win right now: 0 = I refill, 1 = D write-back, 2 = D refill, -1 = nobody.
    function automatic int pick();
        bit ip, dp;
        ip = i_rd_req;
        dp = d_rd_req | d_wr_req;
        if (!ip && !dp) return -1;
        if (ip && (!dp || mdl_last_d)) return 0;
        return d_wr_req ? 1 : 2;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd"},    LW'(m_rd_req), LW'(0));
        chk({tag, "_wr"},    LW'(m_wr_req), LW'(0));
        chk({tag, "_addr"},  LW'(m_addr), LW'(0));
        chk({tag, "_line"},  m_wr_line, LW'(0));
        chk({tag, "_busy"},  LW'(busy), LW'(0));
        chk({tag, "_gnt"},   LW'({i_gnt, d_gnt}), LW'(0));
    endtask

    // One engine transaction, called in an IDLE cycle with requests already driven.
    task automatic xfer(input int lat, input bit mess, input bit drop,
                        input logic [LW-1:0] rline, output int who);
        int            k;
        bit            ewr;
        logic [31:0]   eaddr;
        logic [LW-1:0] eline;
        logic [LW-1:0] got;
        who   = pick();
        eaddr = (who == 0) ? i_addr : d_addr;
        ewr   = (who == 1);
        eline = d_wr_line;
        chk("winner_exists", LW'(who >= 0), LW'(1));
        k = 0;
        while (!(m_rd_req || m_wr_req) && k < 6) begin
            tick();
            k++;
        end
        chk("req_delay", LW'(k), LW'(1));
        if (!(m_rd_req || m_wr_req)) return;
        for (int c = 0; c <= lat; c++) begin
            chk("m_rd_req", LW'(m_rd_req), LW'(!ewr));
            chk("m_wr_req", LW'(m_wr_req), LW'(ewr));
            chk("m_addr", LW'(m_addr), LW'(eaddr));
            if (ewr) chk("m_wr_line", m_wr_line, eline);
            chk("busy_burst", LW'(busy), LW'(1));
            chk("gnt_burst", LW'({i_gnt, d_gnt}), LW'(0));
            if (mess) begin
                d_wr_line = rand_line();
                d_addr    = $urandom;
            end
            if (c < lat) tick();
        end
        m_rd_line = rline;
        m_gnt     = 1'b1;
        #1;
        chk("i_gnt", LW'(i_gnt), LW'(who == 0));
        chk("d_gnt", LW'(d_gnt), LW'(who != 0));
        got = (who == 0) ? i_rd_line : d_rd_line;
        chk("rd_line", got, rline);
        chk("req_in_gnt", LW'(m_rd_req | m_wr_req), LW'(1));
        last_got   = got;
        last_wr    = m_wr_line;
        mdl_last_d = (who != 0);
        if (drop) begin
            case (who)
                0: i_rd_req = 1'b0;
                1: d_wr_req = 1'b0;
                2: d_rd_req = 1'b0;
                default: ;
            endcase
        end
        tick();
        m_gnt = 1'b0;
        #1;
        chk("done_req", LW'({m_rd_req, m_wr_req}), LW'(0));
        chk("done_busy", LW'(busy), LW'(1));
        chk("done_gnt", LW'({i_gnt, d_gnt}), LW'(0));
        tick();
        chk("idle_req", LW'({m_rd_req, m_wr_req}), LW'(0));
        chk("idle_busy", LW'(busy), LW'(0));
    endtask

    initial begin
        int who;
        int order[4];
        int exp_order[4];
        exp_order = '{0, 2, 0, 2};

        aresetn    = 1'b0;
        i_rd_req   = 1'b0;
        i_addr     = 32'd0;
        d_rd_req   = 1'b0;
        d_wr_req   = 1'b0;
        d_addr     = 32'd0;
        d_wr_line  = '0;
        m_gnt      = 1'b0;
        m_rd_line  = '0;
        mdl_last_d = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        aresetn = 1'b1;
        tick();

        // Single I refill
        i_addr   = 32'h1FC0_0000;
        i_rd_req = 1'b1;
        xfer(2, 1'b0, 1'b1, seq_line(32'hA0), who);
        chk("t1_owner", LW'(who), LW'(0));
        chk("t1_word3", LW'(last_got[3*32 +: 32]), LW'(32'hA3));

        // D write-back with client data disturbed mid-burst
        d_addr    = 32'h0000_1000;
        d_wr_line = seq_line(32'h10);
        d_wr_req  = 1'b1;
        xfer(3, 1'b1, 1'b1, rand_line(), who);
        chk("t2_owner", LW'(who), LW'(1));
        chk("t2_word7", LW'(last_wr[7*32 +: 32]), LW'(32'h17));

        // Both caches held for four transfers alternate, I first
        i_addr   = $urandom;
        d_addr   = $urandom;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            xfer(int'($urandom_range(0, 3)), 1'b0, 1'b0, rand_line(), who);
            order[t] = who;
            i_addr   = $urandom;
            d_addr   = $urandom;
        end
        for (int t = 0; t < 4; t++) chk("t3_order", LW'(order[t]), LW'(exp_order[t]));
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        tick();

        // Write-back beats refill inside the D-cache
        d_addr    = $urandom;
        d_wr_line = rand_line();
        d_wr_req  = 1'b1;
        d_rd_req  = 1'b1;
        xfer(1, 1'b0, 1'b1, rand_line(), who);
        chk("t4_first", LW'(who), LW'(1));
        xfer(2, 1'b0, 1'b1, rand_line(), who);
        chk("t4_second", LW'(who), LW'(2));

        // Spurious engine completion in IDLE
        m_rd_line = rand_line();
        m_gnt     = 1'b1;
        #1;
        chk("t5_gnt", LW'({i_gnt, d_gnt}), LW'(0));
        tick();
        m_gnt = 1'b0;
        chk("t5_busy", LW'(busy), LW'(0));
        chk("t5_req", LW'({m_rd_req, m_wr_req}), LW'(0));
        i_addr   = $urandom;
        d_addr   = $urandom;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        xfer(1, 1'b0, 1'b1, rand_line(), who);
        chk("t5_tie", LW'(who), LW'(0));
        xfer(0, 1'b0, 1'b1, rand_line(), who);
        chk("t5_next", LW'(who), LW'(2));

        // Reset during a transfer
        i_addr   = $urandom;
        i_rd_req = 1'b1;
        tick();
        chk("t6_started", LW'(m_rd_req), LW'(1));
        tick();
        aresetn  = 1'b0;
        i_rd_req = 1'b0;
        tick();
        aresetn    = 1'b1;
        mdl_last_d = 1'b1;
        check_reset_outputs("t6_reset");
        i_addr   = $urandom;
        d_addr   = $urandom;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        xfer(2, 1'b0, 1'b1, rand_line(), who);
        chk("t6_after", LW'(who), LW'(0));
        xfer(1, 1'b0, 1'b1, rand_line(), who);
        chk("t6_after_d", LW'(who), LW'(2));

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            if (!i_rd_req && $urandom_range(0, 1) == 1) begin
                i_rd_req = 1'b1;
                i_addr   = $urandom;
            end
            if (!d_rd_req && !d_wr_req) begin
                case ($urandom_range(0, 3))
                    1: d_rd_req = 1'b1;
                    2: d_wr_req = 1'b1;
                    3: begin d_rd_req = 1'b1; d_wr_req = 1'b1; end
                    default: ;
                endcase
                d_addr    = $urandom;
                d_wr_line = rand_line();
            end
            if (!(i_rd_req || d_rd_req || d_wr_req)) begin
                i_rd_req = 1'b1;
                i_addr   = $urandom;
            end
            xfer(int'($urandom_range(0, 4)), 1'b0, 1'b1, rand_line(), who);
        end

        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        d_wr_req = 1'b0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares the single cache-line AXI burst engine between the I-cache (line refill) and the D-cache (line refill and dirty-line write-back). It latches one client request at a time, drives the engine's request port with a stable address and write line for the whole burst, routes the completion grant and read line back to the owner, and alternates ownership so neither cache starves.

## Interface
Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; must equal the engine burst length.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- i_rd_req  in  1  I-cache refill request; held high until i_gnt
- i_addr  in  32  I-cache line address
- i_gnt  out  1  one-cycle completion pulse to I-cache
- i_rd_line  out  32×LINE_WORDS  refill data; valid in the i_gnt cycle
- d_rd_req  in  1  D-cache refill request; held until d_gnt
- d_wr_req  in  1  D-cache write-back request; held until d_gnt
- d_addr  in  32  D-cache line address
- d_wr_line  in  32×LINE_WORDS  write-back data
- d_gnt  out  1  one-cycle completion pulse to D-cache
- d_rd_line  out  32×LINE_WORDS  refill data; valid in the d_gnt cycle
- m_rd_req  out  1  engine read request
- m_wr_req  out  1  engine write request
- m_addr  out  32  engine line address
- m_wr_line  out  32×LINE_WORDS  engine write data
- m_gnt  in  1  engine one-cycle completion pulse
- m_rd_line  in  32×LINE_WORDS  engine read data; valid in the m_gnt cycle
- busy  out  1  high while a transfer is owned

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any request is pending, select a winner, latch owner (I/D), type (RD/WR), addr into m_addr, and, for writes, d_wr_line into the internal line buffer; go to BUSY. Otherwise stay.
- Selection: within D-cache, d_wr_req beats d_rd_req. Between caches, if only one requests it wins. If both request, the client not served last wins (last_owner register, reset value = D, so I wins the first tie).
- BUSY: m_rd_req = owner type RD, m_wr_req = owner type WR; m_addr and m_wr_line held constant from the latched registers, never from live client inputs. Client request changes are ignored. On m_gnt go to DONE and update last_owner.
- Grant routing: in the m_gnt cycle, owner's gnt = 1 combinationally. The owner's rd_line is m_rd_line passed through. The non-owner gnt stays 0.
- DONE: m_rd_req = m_wr_req = 0, and no new request is accepted. This is one cycle so clients can drop their request and the engine returns to idle. Then go to IDLE.
- m_gnt outside BUSY is ignored, with no gnt forwarded.
- Back-to-back D-cache write-back then refill: the second request is accepted in IDLE after DONE, and re-arbitrated against I.

## Timing
- Reset values: state IDLE, m_rd_req 0, m_wr_req 0, m_addr 0, line buffer 0, i_gnt 0, d_gnt 0, busy 0, last_owner D.
- Request at IDLE cycle T: latched at the end of T, and m_*_req is high from T+1. No combinational path from client req to m_*_req.
- m_*_req stays high continuously from T+1 through the m_gnt cycle, and is low in the cycle after m_gnt.
- Minimum spacing between two engine transactions is 2 cycles of m_*_req low (DONE and IDLE).
- busy is high in BUSY and DONE.
- m_rd_req and m_wr_req are never both high.
- Reset mid-transfer returns the block to IDLE next cycle, with no gnt issued and the latched state discarded. The engine resets on the same aresetn.
- Client contract: request held stable until gnt, and dropped the cycle after gnt.

## Test plan
- Single I refill, addr 0x1FC0_0000: m_rd_req rises 1 cycle after i_rd_req and holds. The model returns words 0..7 = 0xA0..0xA7 with m_gnt. i_gnt pulses once with i_rd_line[3] = 0xA3, and d_gnt stays 0.
- D write-back, addr 0x0000_1000, line 0x10..0x17: m_wr_req = 1 and m_wr_line[7] = 0x17 throughout. Changing d_wr_line mid-burst does not change m_wr_line. d_gnt pulses once.
- Simultaneous i_rd_req and d_rd_req after reset: I is served first, then D. With both held continuously for 4 transfers, the order is I, D, I, D.
- d_wr_req and d_rd_req both high, then the client swaps to rd after d_gnt: write-back completes before the refill. Each completion has a 2-cycle m_*_req gap.
- Spurious m_gnt in IDLE: no i_gnt or d_gnt, and the state is unchanged.
- aresetn low for 1 cycle during BUSY: all outputs return to reset values next cycle. A subsequent request completes normally.
